// File: rtl/key_search_scheduler.sv
// Round-robin dispatcher of RC4 candidate keys to a parallel decrypt-core array.
// Optional KEY_SCHED_DESCEND_EN: search from KEY_MAX down to 0 instead of 0 up to KEY_MAX.
module key_search_scheduler #(
   parameter int unsigned          NUM_CORES = 4,
   parameter int unsigned          KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic [NUM_CORES-1:0] core_req,
   input  logic [NUM_CORES-1:0] core_done,
   input  logic [NUM_CORES-1:0] core_pass,
   output logic [NUM_CORES-1:0] core_key_valid,
   output logic [KEY_WIDTH-1:0] core_key,
   output logic                 stop_all,
   output logic                 busy,
   output logic                 found,
   output logic                 exhausted,
   output logic [KEY_WIDTH-1:0] found_key
);

   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

`ifdef KEY_SCHED_DESCEND_EN
   localparam logic [KEY_WIDTH-1:0] FIRST_KEY = KEY_MAX;
   localparam logic [KEY_WIDTH-1:0] LAST_KEY  = '0;
`else
   localparam logic [KEY_WIDTH-1:0] FIRST_KEY = '0;
   localparam logic [KEY_WIDTH-1:0] LAST_KEY  = KEY_MAX;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_DISPATCH, S_DRAIN, S_FOUND, S_EXHAUSTED
   } state_t;

   state_t               state;
   logic [NUM_CORES-1:0] outstanding;
   logic [IDX_W-1:0]     rr_ptr;
   logic [KEY_WIDTH-1:0] next_key;
   logic [KEY_WIDTH-1:0] slot [NUM_CORES];

   logic [NUM_CORES-1:0] done_hit_c;
   logic [NUM_CORES-1:0] pass_hit_c;
   logic [NUM_CORES-1:0] eligible_c;
   logic [NUM_CORES-1:0] remaining_c;
   logic                 grant_any_c;
   logic                 pass_any_c;
   logic [IDX_W-1:0]     grant_idx_c;
   logic [IDX_W-1:0]     pass_idx_c;
   logic [IDX_W-1:0]     rr_next_c;
   int unsigned          idx_c;

   // Eligibility uses the pre-done outstanding mask so a core finishing this cycle waits one cycle.
   always_comb begin
      done_hit_c  = core_done & outstanding;
      pass_hit_c  = done_hit_c & core_pass;
      eligible_c  = core_req & ~outstanding;
      remaining_c = outstanding & ~done_hit_c;
      grant_any_c = 1'b0;
      grant_idx_c = '0;
      pass_any_c  = 1'b0;
      pass_idx_c  = '0;
      idx_c       = 0;
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
         idx_c = 32'(rr_ptr) + k;
         if (idx_c >= NUM_CORES) idx_c = idx_c - NUM_CORES;
         if (!grant_any_c && eligible_c[IDX_W'(idx_c)]) begin
            grant_any_c = 1'b1;
            grant_idx_c = IDX_W'(idx_c);
         end
      end
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
         if (!pass_any_c && pass_hit_c[IDX_W'(i)]) begin
            pass_any_c = 1'b1;
            pass_idx_c = IDX_W'(i);
         end
      end
      rr_next_c = (32'(grant_idx_c) == NUM_CORES - 1) ? '0 : grant_idx_c + 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         outstanding    <= '0;
         rr_ptr         <= '0;
         next_key       <= '0;
         core_key_valid <= '0;
         core_key       <= '0;
         stop_all       <= 1'b0;
         busy           <= 1'b0;
         found          <= 1'b0;
         exhausted      <= 1'b0;
         found_key      <= '0;
         for (int unsigned i = 0; i < NUM_CORES; i++) slot[IDX_W'(i)] <= '0;
      end else begin
         core_key_valid <= '0;
         case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
               outstanding <= '0;
               if (start) begin
                  state     <= S_DISPATCH;
                  busy      <= 1'b1;
                  found     <= 1'b0;
                  exhausted <= 1'b0;
                  stop_all  <= 1'b0;
                  found_key <= '0;
                  next_key  <= FIRST_KEY;
               end
            end
            S_DISPATCH, S_DRAIN: begin
               if (pass_any_c) begin
                  found_key   <= slot[pass_idx_c];
                  found       <= 1'b1;
                  stop_all    <= 1'b1;
                  busy        <= 1'b0;
                  outstanding <= '0;
                  state       <= S_FOUND;
               end else if (state == S_DRAIN) begin
                  outstanding <= remaining_c;
                  if (remaining_c == '0) begin
                     state     <= S_EXHAUSTED;
                     exhausted <= 1'b1;
                     busy      <= 1'b0;
                  end
               end else if (grant_any_c) begin
                  core_key_valid      <= NUM_CORES'(1) << grant_idx_c;
                  core_key            <= next_key;
                  slot[grant_idx_c]   <= next_key;
                  outstanding         <= remaining_c | (NUM_CORES'(1) << grant_idx_c);
                  rr_ptr              <= rr_next_c;
                  // The last key moves to DRAIN; next_key is left in place so it never wraps.
                  if (next_key == LAST_KEY) begin
                     state <= S_DRAIN;
                  end else begin
`ifdef KEY_SCHED_DESCEND_EN
                     next_key <= next_key - 1'b1;
`else
                     next_key <= next_key + 1'b1;
`endif
                  end
               end else begin
                  outstanding <= remaining_c;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_key_search_scheduler.sv
// Directed bench for key_search_scheduler (4 cores, 16-key space).
// Expected keys follow KEY_SCHED_DESCEND_EN when it is defined.
module tb_key_search_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [3:0]  core_req;
   logic [3:0]  core_done;
   logic [3:0]  core_pass;
   logic [3:0]  core_key_valid;
   logic [23:0] core_key;
   logic        stop_all;
   logic        busy;
   logic        found;
   logic        exhausted;
   logic [23:0] found_key;

   int total = 0;
   int bad   = 0;

   key_search_scheduler #(
      .NUM_CORES(4),
      .KEY_WIDTH(24),
      .KEY_MAX  (24'd15)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .core_req      (core_req),
      .core_done     (core_done),
      .core_pass     (core_pass),
      .core_key_valid(core_key_valid),
      .core_key      (core_key),
      .stop_all      (stop_all),
      .busy          (busy),
      .found         (found),
      .exhausted     (exhausted),
      .found_key     (found_key)
   );

   always #5 clk = ~clk;

   // n-th key handed out by a fresh search.
   function automatic logic [23:0] key_at(input int n);
`ifdef KEY_SCHED_DESCEND_EN
      return 24'(15 - n);
`else
      return 24'(n);
`endif
   endfunction

   task automatic do_reset();
      reset_n   = 1'b0;
      start     = 1'b0;
      core_req  = '0;
      core_done = '0;
      core_pass = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_grant(input int max_cyc, output logic got);
      got = 1'b0;
      for (int c = 0; c < max_cyc && !got; c++) begin
         @(negedge clk);
         if (core_key_valid != '0) got = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      start = 1'b0; core_req = '0; core_done = '0; core_pass = '0;
      #12;
      total++;
      if ({core_key_valid, core_key, stop_all, busy, found, exhausted, found_key} !== '0) begin
         bad++;
         $display("FAIL reset_outputs: got valid=%b key=%0d stop=%b busy=%b found=%b exh=%b fkey=%0d, want all 0",
                  core_key_valid, core_key, stop_all, busy, found, exhausted, found_key);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      total++;
      if ({core_key_valid, busy, found, exhausted} !== '0) begin
         bad++;
         $display("FAIL idle_after_reset: got valid=%b busy=%b found=%b exh=%b, want 0",
                  core_key_valid, busy, found, exhausted);
      end
   endtask

   task automatic test_dispatch();
      do_reset();
      start = 1'b1; core_req = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1 || core_key_valid !== 4'b0000) begin
         bad++;
         $display("FAIL dispatch_enter: got busy=%b valid=%b, want busy=1 valid=0000", busy, core_key_valid);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         total++;
         if (core_key_valid !== 4'(1 << i) || core_key !== key_at(i)) begin
            bad++;
            $display("FAIL dispatch_grant%0d: got valid=%b key=%0d, want valid=%b key=%0d",
                     i, core_key_valid, core_key, 4'(1 << i), key_at(i));
         end
      end
      repeat (2) begin
         @(negedge clk);
         total++;
         if (core_key_valid !== 4'b0000) begin
            bad++;
            $display("FAIL dispatch_all_busy: got valid=%b, want 0000", core_key_valid);
         end
      end
   endtask

   // Continues from test_dispatch: all four cores hold a key, RR pointer back at core 0.
   task automatic test_regrant();
      core_done = 4'b0100; core_pass = 4'b0000;
      @(negedge clk);
      core_done = '0;
      total++;
      if (core_key_valid !== 4'b0000) begin
         bad++;
         $display("FAIL regrant_same_cycle: got valid=%b, want 0000", core_key_valid);
      end
      @(negedge clk);
      total++;
      if (core_key_valid !== 4'b0100 || core_key !== key_at(4)) begin
         bad++;
         $display("FAIL regrant_core2: got valid=%b key=%0d, want 0100 key=%0d", core_key_valid, core_key, key_at(4));
      end
      core_done = 4'b1001;
      @(negedge clk);
      core_done = '0;
      @(negedge clk);
      total++;
      if (core_key_valid !== 4'b1000 || core_key !== key_at(5)) begin
         bad++;
         $display("FAIL regrant_rr_core3: got valid=%b key=%0d, want 1000 key=%0d", core_key_valid, core_key, key_at(5));
      end
      @(negedge clk);
      total++;
      if (core_key_valid !== 4'b0001 || core_key !== key_at(6)) begin
         bad++;
         $display("FAIL regrant_rr_core0: got valid=%b key=%0d, want 0001 key=%0d", core_key_valid, core_key, key_at(6));
      end
   endtask

   task automatic test_found();
      logic got;
      int   extra;
      do_reset();
      start = 1'b1; core_req = 4'b0010;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         wait_grant(6, got);
         total++;
         if (!got || core_key_valid !== 4'b0010 || core_key !== key_at(k)) begin
            bad++;
            $display("FAIL found_grant%0d: got seen=%b valid=%b key=%0d, want 0010 key=%0d",
                     k, got, core_key_valid, core_key, key_at(k));
         end
         core_done = 4'b0010;
         core_pass = (k == 9) ? 4'b0010 : 4'b0000;
         @(negedge clk);
         core_done = '0; core_pass = '0;
      end
      total++;
      if (found !== 1'b1 || found_key !== key_at(9) || stop_all !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL found_flags: got found=%b fkey=%0d stop=%b busy=%b, want 1 %0d 1 0",
                  found, found_key, stop_all, busy, key_at(9));
      end
      extra = 0;
      repeat (5) begin
         @(negedge clk);
         if (core_key_valid != '0) extra++;
      end
      total++;
      if (extra !== 0 || found !== 1'b1) begin
         bad++;
         $display("FAIL found_hold: got grants=%0d found=%b, want 0 grants found=1", extra, found);
      end
   endtask

   task automatic test_exhaust();
      int exp_n, last_cyc, exh_cyc;
      do_reset();
      start = 1'b1; core_req = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      exp_n = 0; last_cyc = -100; exh_cyc = -1;
      for (int c = 0; c < 80 && exh_cyc < 0; c++) begin
         @(negedge clk);
         if (exhausted === 1'b1) exh_cyc = c;
         core_done = core_key_valid;
         if (core_key_valid != '0) begin
            total++;
            if (core_key !== key_at(exp_n)) begin
               bad++;
               $display("FAIL exhaust_key%0d: got key=%0d, want %0d", exp_n, core_key, key_at(exp_n));
            end
            exp_n++;
            last_cyc = c;
         end
      end
      core_done = '0;
      total++;
      if (exp_n !== 16 || exh_cyc !== last_cyc + 1) begin
         bad++;
         $display("FAIL exhaust_timing: got keys=%0d exh_cycle=%0d last_grant=%0d, want 16 keys, exh one after",
                  exp_n, exh_cyc, last_cyc);
      end
      total++;
      if (found !== 1'b0 || busy !== 1'b0 || found_key !== 24'd0 || stop_all !== 1'b0) begin
         bad++;
         $display("FAIL exhaust_flags: got found=%b busy=%b fkey=%0d stop=%b, want 0 0 0 0",
                  found, busy, found_key, stop_all);
      end
   endtask

   task automatic test_multi_pass();
      do_reset();
      start = 1'b1; core_req = 4'b1000;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      core_req = 4'b1001;
      total++;
      if (core_key_valid !== 4'b1000 || core_key !== key_at(0)) begin
         bad++;
         $display("FAIL multi_grant3: got valid=%b key=%0d, want 1000 key=%0d", core_key_valid, core_key, key_at(0));
      end
      @(negedge clk);
      total++;
      if (core_key_valid !== 4'b0001 || core_key !== key_at(1)) begin
         bad++;
         $display("FAIL multi_grant0: got valid=%b key=%0d, want 0001 key=%0d", core_key_valid, core_key, key_at(1));
      end
      @(negedge clk);
      core_done = 4'b0110; core_pass = 4'b0110;
      @(negedge clk);
      total++;
      if (found !== 1'b0 || busy !== 1'b1 || stop_all !== 1'b0) begin
         bad++;
         $display("FAIL spurious_done: got found=%b busy=%b stop=%b, want 0 1 0", found, busy, stop_all);
      end
      core_done = 4'b1001; core_pass = 4'b1001;
      @(negedge clk);
      core_done = '0; core_pass = '0;
      total++;
      if (found !== 1'b1 || found_key !== key_at(1) || stop_all !== 1'b1) begin
         bad++;
         $display("FAIL multi_pass_lowest: got found=%b fkey=%0d stop=%b, want 1 %0d 1",
                  found, found_key, stop_all, key_at(1));
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      total++;
      if (found !== 1'b0 || found_key !== 24'd0 || stop_all !== 1'b0 || busy !== 1'b1) begin
         bad++;
         $display("FAIL rearm_from_found: got found=%b fkey=%0d stop=%b busy=%b, want 0 0 0 1",
                  found, found_key, stop_all, busy);
      end
   endtask

   task automatic test_async_reset();
      logic got;
      do_reset();
      start = 1'b1; core_req = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      total++;
      if ({core_key_valid, core_key, stop_all, busy, found, exhausted, found_key} !== '0) begin
         bad++;
         $display("FAIL async_reset: got valid=%b key=%0d busy=%b found=%b, want all 0",
                  core_key_valid, core_key, busy, found);
      end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_grant(4, got);
      total++;
      if (!got || core_key_valid !== 4'b0001 || core_key !== key_at(0)) begin
         bad++;
         $display("FAIL restart_first_key: got seen=%b valid=%b key=%0d, want 0001 key=%0d",
                  got, core_key_valid, core_key, key_at(0));
      end
   endtask

   initial begin
      test_reset();
      test_dispatch();
      test_regrant();
      test_found();
      test_exhaust();
      test_multi_pass();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
